// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath:
// instruction fields and the zero flag come in, mux selects and enables go out.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes aluop+funct into the 3-bit ALU operation.
//
// state    | meaning
// FETCH    | load IR from mem[PC], PC <= PC+4
// DECODE   | read registers, precompute branch target into ALUOut
// MEMADR   | compute lw/sw effective address
// MEMRD    | read data memory at ALUOut
// MEMWB    | write loaded data to rt
// MEMWR    | write register B to memory at ALUOut
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | compare A-B, take branch on zero
// ADDIEXEC | A + SignImm
// ADDIWB   | write addi result to rt
// JUMP     | load jump target into PC
module mips_mc_controller (
    input  logic                   clk,
    input  logic                   reset,
    mips_mc_controller_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state, state_next;
    logic       pcwrite, branch;
    logic [1:0] aluop;
    logic       irwrite_s, memwrite_s, regwrite_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = FETCH;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        aluop          = 2'b00;
        irwrite_s      = 1'b0;
        memwrite_s     = 1'b0;
        regwrite_s     = 1'b0;
        bus.iord       = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.illegal_op = 1'b0;
        case (state)
            FETCH: begin
                irwrite_s   = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
                state_next  = DECODE;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next     = FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_next  = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.iord   = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                regwrite_s   = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b10;
                state_next  = ALUWB;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                bus.regdst = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b01;
                branch      = 1'b1;
                bus.pcsrc   = 2'b01;
            end
            ADDIEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_next  = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
            end
            JUMP: begin
                pcwrite   = 1'b1;
                bus.pcsrc = 2'b10;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset gates the enables combinationally so an in-flight write dies at once.
    assign bus.irwrite  = irwrite_s  & ~reset;
    assign bus.memwrite = memwrite_s & ~reset;
    assign bus.regwrite = regwrite_s & ~reset;
    assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;

    always_comb begin
        bus.alucontrol = 3'b010;
        if (aluop == 2'b01) begin
            bus.alucontrol = 3'b110;
        end else if (aluop == 2'b10) begin
            case (bus.funct)
                6'b100010: bus.alucontrol = 3'b110;
                6'b100100: bus.alucontrol = 3'b000;
                6'b100101: bus.alucontrol = 3'b001;
                6'b101010: bus.alucontrol = 3'b111;
                default:   bus.alucontrol = 3'b010;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class through
// its state sequence and compares the full control word against hand values.
module tb_mips_mc_controller;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mips_mc_controller_if bus();

    mips_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    //  alusrcb[1:0], pcsrc[1:0], pcen, alucontrol[2:0], illegal_op}
    logic [15:0] ctl;
    assign ctl = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                  bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                  bus.alucontrol, bus.illegal_op};

    function automatic logic [15:0] cw(
        input logic iord, input logic mw, input logic ir, input logic rd,
        input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] pcs, input logic pcen, input logic [2:0] aluc,
        input logic ill);
        return {iord, mw, ir, rd, m2r, rw, asa, asb, pcs, pcen, aluc, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (ctl === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, ctl, exp);
        end
    endtask

    logic [15:0] w_fetch, w_fetch_rst, w_decode;
    logic [5:0]  rfunct [6];
    logic [2:0]  raluc  [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        w_fetch     = cw(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
        w_fetch_rst = cw(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
        w_decode    = cw(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
        rfunct = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, 6'b111111};
        raluc  = '{3'b110,    3'b000,    3'b001,    3'b111,    3'b010,    3'b010};

        reset = 1'b1;
        bus.op = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        tick();
        check("reset_c1", w_fetch_rst);
        tick();
        tick();
        check("reset_c3", w_fetch_rst);
        reset = 1'b0;
        #1;
        check("fetch_after_reset", w_fetch);

        // lw: FETCH DECODE MEMADR MEMRD MEMWB FETCH
        bus.op = 6'b100011;
        tick();
        check("lw_decode", w_decode);
        tick();
        check("lw_memadr", cw(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        tick();
        check("lw_memrd", cw(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        tick();
        check("lw_memwb", cw(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0));
        tick();
        check("lw_fetch", w_fetch);

        // R-type across funct codes
        for (int i = 0; i < 6; i++) begin
            bus.op = 6'b000000;
            bus.funct = rfunct[i];
            tick();
            check($sformatf("r%0d_decode", i), w_decode);
            tick();
            check($sformatf("r%0d_execute", i), cw(0,0,0,0,0,0,1,2'b00,2'b00,0,raluc[i],0));
            tick();
            check($sformatf("r%0d_aluwb", i), cw(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0));
            tick();
            check($sformatf("r%0d_fetch", i), w_fetch);
        end

        // beq: zero steers pcen combinationally
        bus.op = 6'b000100;
        bus.funct = 6'b100101;
        tick();
        check("beq_decode", w_decode);
        tick();
        bus.zero = 1'b1;
        #1;
        check("beq_taken", cw(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0));
        bus.zero = 1'b0;
        #1;
        check("beq_not_taken", cw(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,0));
        tick();
        check("beq_fetch", w_fetch);

        // addi
        bus.op = 6'b001000;
        bus.zero = 1'b1;
        tick();
        check("addi_decode", w_decode);
        tick();
        check("addi_exec", cw(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        tick();
        check("addi_wb", cw(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0));
        tick();
        check("addi_fetch", w_fetch);
        bus.zero = 1'b0;

        // j
        bus.op = 6'b000010;
        tick();
        check("j_decode", w_decode);
        tick();
        check("j_jump", cw(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0));
        tick();
        check("j_fetch", w_fetch);

        // sw, reset pulsed mid-MEMWR
        bus.op = 6'b101011;
        tick();
        check("sw_decode", w_decode);
        tick();
        check("sw_memadr", cw(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        tick();
        check("sw_memwr", cw(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        #2;
        reset = 1'b1;
        #1;
        check("sw_reset_async", w_fetch_rst);
        tick();
        check("sw_reset_hold", w_fetch_rst);
        reset = 1'b0;
        #1;
        check("sw_after_reset", w_fetch);
        tick();
        check("sw_reset_decode", w_decode);
        tick();
        check("sw_rerun_memadr", cw(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        tick();
        tick();
        check("sw_rerun_fetch", w_fetch);

        // unsupported opcode
        bus.op = 6'b111111;
        tick();
        check("ill_decode", cw(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1));
        tick();
        check("ill_fetch", w_fetch);
        bus.op = 6'b000000;
        bus.funct = 6'b100000;
        tick();
        check("ill_next_decode", w_decode);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Control unit for the multicycle MIPS datapath, directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable, and produces the 3-bit alucontrol that the ALU consumes. The ALU's zero flag returns to this block to resolve beq.

Parameters:
None. Opcode and funct encodings are fixed by the MIPS ISA subset: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag for the current cycle
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load enable
regdst  output  1  destination register select: 0=rt, 1=rd
memtoreg  output  1  writeback data select: 0=ALUOut, 1=Data
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0=PC, 1=register A
alusrcb  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
pcen  output  1  PC load enable
alucontrol  output  3  ALU operation code
illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- State register is 4 bits and updates on the rising edge of clk. reset asserted -> state=FETCH immediately, regardless of clk.
- While reset is high, all outputs take their FETCH values, except irwrite, pcen, regwrite and memwrite, which are forced to 0.
- Outputs are Moore, decoded from state only, with two exceptions:
  - pcen = pcwrite | (branch & zero)
  - alucontrol is combinational from the state's internal aluop and funct.
- Any output not listed for a state is 0.
- States, asserted outputs and next state:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00 -> DECODE
  - DECODE: alusrcb=11, aluop=00 (precompute branch target)
    - op lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEXEC
    - j -> JUMP
    - any other op -> FETCH with illegal_op=1
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if lw, MEMWR if sw
  - MEMRD: iord=1 -> MEMWB
  - MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH
  - MEMWR: iord=1, memwrite=1 -> FETCH
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB
  - ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 -> FETCH
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH
  - JUMP: pcwrite=1, pcsrc=10 -> FETCH
- The 4 unused state encodings transition to FETCH with all enables 0.
- ALU decode:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 11 -> 010
  - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other funct -> 010
- Cycles per instruction, counting from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset mid-instruction (e.g. asserted in MEMWR): memwrite deasserts in the same cycle and no partial writeback occurs. After reset deasserts, the first rising edge leaves FETCH (into DECODE).
- op and funct are sampled combinationally. The datapath holds the IR stable from DECODE onward.

Test Plan:
- reset=1 for 3 cycles, then release -> state FETCH, pcen=0, irwrite=0 during reset; first post-reset cycle shows irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) -> DECODE, MEMADR (alusrcb=10, alucontrol=010), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1), FETCH; 5 cycles total.
- op=000000 with funct 100010, 100100, 100101 and 101010 -> alucontrol in EXECUTE is 110, 000, 001 and 111 respectively; ALUWB has regwrite=1, regdst=1.
- op=000100 (beq) in BRANCH: zero=1 -> pcen=1, pcsrc=01; zero=0 -> pcen=0; alucontrol=110 in both cases.
- op=101011 (sw), reset pulsed during MEMWR -> memwrite falls to 0 without waiting for clk; state is FETCH.
- op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no regwrite or memwrite asserted.
